idli_sqi_mem_m: RTL and testbench
=================================

# idli_sqi_mem_m

Synthesisable SQI serial-SRAM responder: the memory end of the core's SQI link, modelling one 64 KiB 23LC-style device in quad-I/O sequential mode. Oversamples SCK, CS and SIO on the core clock, decodes READ/WRITE, takes a 16b address, inserts the READ dummy byte and streams nibbles with auto-increment. Two instances (HI and LO) sit behind the core's SQI interface in simulation and FPGA builds; a backdoor port lets benches preload and inspect contents.

## Interface
- ADDR_W, 16, implemented address bits; array is 2^ADDR_W bytes; incoming address bits above ADDR_W ignored.
- i_sqi_gck  in  1  core clock; all logic on posedge; must run at ≥2× SCK.
- i_sqi_rst_n  in  1  one clock; reset is asynchronous and active-low.
- i_sqi_sck  in  1  serial clock from initiator; sampled on i_sqi_gck.
- i_sqi_cs  in  1  chip select, active low; high = deselected.
- i_sqi_sio  in  4  SIO from initiator, bit 3 = SIO3.
- o_sqi_sio  out  4  SIO driven by responder.
- o_sqi_en  out  1  responder output enable for SIO.
- i_bd_wr  in  1  backdoor byte write strobe.
- i_bd_addr  in  ADDR_W  backdoor address.
- i_bd_data  in  8  backdoor write data.
- o_bd_data  out  8  combinational read of array at i_bd_addr.

## Operation
- Edge detect: sck_q flop (reset 0) holds previous i_sqi_sck. Rise = i_sqi_sck & ~sck_q; fall = ~i_sqi_sck & sck_q. Edges count only when i_sqi_cs sampled 0 in the same cycle.
- Nibble order MSB first: instruction, address [15:12] first, data high nibble then low nibble per byte.
- States: IDLE, INSTR, ADDR, DUMMY, RD_DATA, WR_DATA, ERROR. 3b nibble counter cnt.
- Any state: i_sqi_cs sampled 1 -> IDLE, cnt=0, o_sqi_en=0; partial data byte discarded.
- IDLE: i_sqi_cs sampled 0 -> INSTR.
- INSTR: 2 rises shift in opcode. 0x03 -> ADDR (read), 0x02 -> ADDR (write), anything else -> ERROR.
- ADDR: 4 rises shift address; after 4th -> DUMMY if read, WR_DATA if write.
- DUMMY (read only): 2 rises ignored (SIO input don't-care). On the fall following the 2nd dummy rise: o_sqi_en=1, o_sqi_sio=mem[addr][7:4], -> RD_DATA.
- RD_DATA: each fall drives next nibble: low nibble of current byte, then high nibble of addr+1. Increment at byte boundary.
- WR_DATA: rise 1 latches high nibble; rise 2 commits {hi, i_sqi_sio} to mem[addr], addr+1.
- Address wrap: 2^ADDR_W-1 + 1 -> 0, both directions.
- ERROR: ignore everything, o_sqi_en=0, until CS high.
- Stall: SCK held low any number of cycles -> no state, output or address change.
- Backdoor: i_bd_wr writes array only when i_sqi_cs sampled 1; ignored while selected. o_bd_data reflects commits from the cycle after the write.
- Reset: state IDLE, cnt=0, addr=0, sck_q=0, o_sqi_sio=0, o_sqi_en=0. Array contents not reset. Reset mid-transaction aborts it; no partial byte written.

## Timing
- Input capture: i_sqi_sio sampled on the same gck edge that detects the rise.
- Output launch: o_sqi_sio/o_sqi_en registered, change on the gck edge that detects a fall; stable through the next rise (≥1 GCK setup at 2× oversampling).
- o_sqi_en drops on the gck edge sampling CS=1 (1 GCK after CS rises); SIO value then held, don't-care.
- Write commit latency: array updated on the gck edge detecting the 2nd nibble's rise.
- READ: first data nibble valid after 2 instr + 4 addr + 2 dummy SCK = 8 SCK; thereafter 1 nibble/SCK, 1 byte/2 SCK.

## Test plan
- Reset: assert i_sqi_rst_n=0 mid-READ -> o_sqi_en=0, o_sqi_sio=0; next transaction decodes from INSTR cleanly.
- WRITE 0x02, addr 0x1234, data 0xA5,0x3C -> o_bd_data at 0x1234=0xA5, 0x1235=0x3C; o_sqi_en stays 0 throughout.
- Backdoor 0xBEEF=0x12, 0xBEF0=0x34; READ 0x03 addr 0xBEEF -> nibbles 1,2,3,4 on SIO, o_sqi_en rising at fall after 8th SCK rise.
- Wrap: backdoor 0xFFFF=0x9A, 0x0000=0x7E; READ from 0xFFFF -> 9,A,7,E.
- Abort/stall: WRITE addr 0x0010, one nibble, CS high -> 0x0010 unchanged; READ with SCK held low 10 GCK mid-byte -> nibble sequence unaltered.
- Bad opcode 0x05 then 8 SCK of data -> ERROR, o_sqi_en=0, no array change; backdoor write during CS low ignored.

Source files
------------

// File: rtl/idli_sqi_mem_m.sv
// SQI serial-SRAM responder: one 2^ADDR_W byte device in quad sequential mode,
// oversampling SCK/CS/SIO on the core clock, with a backdoor port for preload/inspection.
module idli_sqi_mem_m #(
  parameter int ADDR_W = 16
) (
  input  logic              i_sqi_gck,
  input  logic              i_sqi_rst_n,
  input  logic              i_sqi_sck,
  input  logic              i_sqi_cs,
  input  logic [3:0]        i_sqi_sio,
  output logic [3:0]        o_sqi_sio,
  output logic              o_sqi_en,
  input  logic              i_bd_wr,
  input  logic [ADDR_W-1:0] i_bd_addr,
  input  logic [7:0]        i_bd_data,
  output logic [7:0]        o_bd_data
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INSTR   = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DUMMY   = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_WR_DATA = 3'd5,
    ST_ERROR   = 3'd6
  } state_e;

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0]        mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        op_q, op_d;
  logic              is_rd_q, is_rd_d;
  logic [3:0]        hi_q, hi_d;
  logic              sck_q;
  logic [3:0]        sio_q, sio_d;
  logic              en_q, en_d;

  logic              sel_s, rise_s, fall_s;
  logic [7:0]        opcode_s;
  logic [ADDR_W-1:0] addr_inc_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [7:0]        mem_wdata_s;

  assign sel_s      = ~i_sqi_cs;
  assign rise_s     = sel_s & i_sqi_sck & ~sck_q;
  assign fall_s     = sel_s & ~i_sqi_sck & sck_q;
  assign opcode_s   = {op_q, i_sqi_sio};
  assign addr_inc_s = addr_q + ADDR_W'(1);

  assign o_sqi_sio  = sio_q;
  assign o_sqi_en   = en_q;
  assign o_bd_data  = mem_q[i_bd_addr];

  // State and datapath registers
  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      op_q    <= 4'h0;
      is_rd_q <= 1'b0;
      hi_q    <= 4'h0;
      sck_q   <= 1'b0;
      sio_q   <= 4'h0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      is_rd_q <= is_rd_d;
      hi_q    <= hi_d;
      sck_q   <= i_sqi_sck;
      sio_q   <= sio_d;
      en_q    <= en_d;
    end
  end

  // Array write port; contents deliberately survive reset
  always_ff @(posedge i_sqi_gck) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    if (!sel_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_INSTR;
        ST_INSTR: begin
          if (rise_s && (cnt_q == 3'd1)) begin
            if ((opcode_s == 8'h03) || (opcode_s == 8'h02)) begin
              state_d = ST_ADDR;
            end else begin
              state_d = ST_ERROR;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_ADDR: begin
          if (rise_s && (cnt_q == 3'd3)) begin
            state_d = is_rd_q ? ST_DUMMY : ST_WR_DATA;
          end else begin
            state_d = state_q;
          end
        end
        ST_DUMMY: begin
          if (fall_s && (cnt_q == 3'd2)) begin
            state_d = ST_RD_DATA;
          end else begin
            state_d = state_q;
          end
        end
        ST_RD_DATA: state_d = ST_RD_DATA;
        ST_WR_DATA: state_d = ST_WR_DATA;
        ST_ERROR:   state_d = ST_ERROR;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Counters, shifters, output drive and array write requests
  always_comb begin
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    op_d        = op_q;
    is_rd_d     = is_rd_q;
    hi_d        = hi_q;
    sio_d       = sio_q;
    en_d        = en_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = addr_q;
    mem_wdata_s = {hi_q, i_sqi_sio};
    if (!sel_s) begin
      // Deselected: abandon any partial byte; only now may the backdoor write
      cnt_d = 3'd0;
      en_d  = 1'b0;
      if (i_bd_wr) begin
        mem_we_s    = 1'b1;
        mem_waddr_s = i_bd_addr;
        mem_wdata_s = i_bd_data;
      end else begin
        mem_we_s = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: cnt_d = 3'd0;
        ST_INSTR: begin
          if (rise_s) begin
            if (cnt_q == 3'd0) begin
              op_d  = i_sqi_sio;
              cnt_d = 3'd1;
            end else begin
              is_rd_d = (opcode_s == 8'h03);
              cnt_d   = 3'd0;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_ADDR: begin
          if (rise_s) begin
            addr_d = {addr_q[ADDR_W-5:0], i_sqi_sio};
            cnt_d  = (cnt_q == 3'd3) ? 3'd0 : (cnt_q + 3'd1);
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_DUMMY: begin
          if (rise_s && (cnt_q != 3'd2)) begin
            cnt_d = cnt_q + 3'd1;
          end else if (fall_s && (cnt_q == 3'd2)) begin
            en_d  = 1'b1;
            sio_d = mem_q[addr_q][7:4];
            cnt_d = 3'd0;
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_RD_DATA: begin
          // cnt_q[0] tracks which half of the current byte is on the pins
          if (fall_s) begin
            if (cnt_q == 3'd0) begin
              sio_d = mem_q[addr_q][3:0];
              cnt_d = 3'd1;
            end else begin
              addr_d = addr_inc_s;
              sio_d  = mem_q[addr_inc_s][7:4];
              cnt_d  = 3'd0;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_WR_DATA: begin
          if (rise_s) begin
            if (cnt_q == 3'd0) begin
              hi_d  = i_sqi_sio;
              cnt_d = 3'd1;
            end else begin
              mem_we_s = 1'b1;
              addr_d   = addr_inc_s;
              cnt_d    = 3'd0;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_ERROR: en_d = 1'b0;
        default: begin
          cnt_d = 3'd0;
          en_d  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Directed bench for idli_sqi_mem_m: an SQI initiator model drives transactions,
// a scoreboard queue holds expected read nibbles checked on every SCK rise.
module tb_idli_sqi_mem_m;

  logic        gck = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        cs = 1'b1;
  logic [3:0]  sio_i = 4'h0;
  logic [3:0]  sio_o;
  logic        en_o;
  logic        bd_wr = 1'b0;
  logic [15:0] bd_addr = 16'h0000;
  logic [7:0]  bd_data = 8'h00;
  logic [7:0]  bd_q;

  int          errors = 0;
  int          checks = 0;
  logic [3:0]  exp_q [$];
  logic [3:0]  mon_e;

  idli_sqi_mem_m #(.ADDR_W(16)) dut (
    .i_sqi_gck   (gck),
    .i_sqi_rst_n (rst_n),
    .i_sqi_sck   (sck),
    .i_sqi_cs    (cs),
    .i_sqi_sio   (sio_i),
    .o_sqi_sio   (sio_o),
    .o_sqi_en    (en_o),
    .i_bd_wr     (bd_wr),
    .i_bd_addr   (bd_addr),
    .i_bd_data   (bd_data),
    .o_bd_data   (bd_q)
  );

  always #5 gck = ~gck;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Initiator samples responder SIO on each SCK rise
  always @(posedge sck) begin
    if (en_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_sio_en", {4'h0, sio_o}, 8'hEE);
      end else begin
        mon_e = exp_q.pop_front();
        check("read_nibble", {4'h0, sio_o}, {4'h0, mon_e});
      end
    end
  end

  task automatic nib(input logic [3:0] n, input int stall = 0);
    @(negedge gck);
    sck   = 1'b0;
    sio_i = n;
    repeat (1 + stall) @(negedge gck);
    @(negedge gck);
    sck = 1'b1;
    @(negedge gck);
  endtask

  task automatic start_tx();
    @(negedge gck);
    cs  = 1'b0;
    sck = 1'b0;
    repeat (2) @(negedge gck);
  endtask

  task automatic end_tx();
    @(negedge gck);
    sck = 1'b0;
    repeat (2) @(negedge gck);
    cs = 1'b1;
    repeat (3) @(negedge gck);
  endtask

  task automatic hdr(input logic [7:0] op, input logic [15:0] a);
    nib(op[7:4]);
    nib(op[3:0]);
    for (int i = 3; i >= 0; i--) nib(a[4*i +: 4]);
  endtask

  task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge gck);
    bd_wr   = 1'b1;
    bd_addr = a;
    bd_data = d;
    @(negedge gck);
    bd_wr = 1'b0;
  endtask

  task automatic bd_check(input string name, input logic [15:0] a, input logic [7:0] exp);
    @(negedge gck);
    bd_addr = a;
    #1;
    check(name, bd_q, exp);
  endtask

  task automatic read4(input logic [15:0] a, input int stall_at);
    start_tx();
    hdr(8'h03, a);
    nib(4'hF);
    nib(4'hF);
    check("en_low_before_data", {7'h0, en_o}, 8'h00);
    for (int k = 0; k < 4; k++) nib(4'h0, (k == stall_at) ? 10 : 0);
    end_tx();
    check("en_low_after_cs", {7'h0, en_o}, 8'h00);
    check("read_queue_drained", 8'(exp_q.size()), 8'h00);
  endtask

  initial begin
    repeat (3) @(negedge gck);
    check("reset_en", {7'h0, en_o}, 8'h00);
    check("reset_sio", {4'h0, sio_o}, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge gck);

    // WRITE 0x1234 <= A5, 3C
    start_tx();
    hdr(8'h02, 16'h1234);
    nib(4'hA); nib(4'h5); nib(4'h3); nib(4'hC);
    check("wr_en_low", {7'h0, en_o}, 8'h00);
    end_tx();
    bd_check("wr_byte0", 16'h1234, 8'hA5);
    bd_check("wr_byte1", 16'h1235, 8'h3C);

    // READ across a byte boundary
    bd_write(16'hBEEF, 8'h12);
    bd_write(16'hBEF0, 8'h34);
    exp_q.push_back(4'h1); exp_q.push_back(4'h2);
    exp_q.push_back(4'h3); exp_q.push_back(4'h4);
    read4(16'hBEEF, -1);

    // Address wrap
    bd_write(16'hFFFF, 8'h9A);
    bd_write(16'h0000, 8'h7E);
    exp_q.push_back(4'h9); exp_q.push_back(4'hA);
    exp_q.push_back(4'h7); exp_q.push_back(4'hE);
    read4(16'hFFFF, -1);

    // Aborted write after one nibble
    bd_write(16'h0010, 8'h66);
    start_tx();
    hdr(8'h02, 16'h0010);
    nib(4'h5);
    end_tx();
    bd_check("abort_unchanged", 16'h0010, 8'h66);

    // SCK stall mid-byte
    exp_q.push_back(4'hA); exp_q.push_back(4'h5);
    exp_q.push_back(4'h3); exp_q.push_back(4'hC);
    read4(16'h1234, 1);

    // Bad opcode, then backdoor attempt while selected
    bd_write(16'h0020, 8'h11);
    bd_write(16'h2222, 8'h55);
    start_tx();
    nib(4'h0); nib(4'h5);
    for (int k = 0; k < 8; k++) nib(4'h2);
    bd_write(16'h0020, 8'hFF);
    check("err_en_low", {7'h0, en_o}, 8'h00);
    end_tx();
    bd_check("err_bd_ignored", 16'h0020, 8'h11);
    bd_check("err_no_write", 16'h2222, 8'h55);

    // Reset mid-READ
    exp_q.push_back(4'h1);
    start_tx();
    hdr(8'h03, 16'hBEEF);
    nib(4'hF); nib(4'hF); nib(4'h0);
    @(negedge gck);
    sck = 1'b0;
    repeat (2) @(negedge gck);
    rst_n = 1'b0;
    #1;
    check("midrd_reset_en", {7'h0, en_o}, 8'h00);
    check("midrd_reset_sio", {4'h0, sio_o}, 8'h00);
    @(negedge gck);
    cs = 1'b1;
    repeat (2) @(negedge gck);
    rst_n = 1'b1;
    repeat (2) @(negedge gck);
    exp_q.push_back(4'h1); exp_q.push_back(4'h2);
    exp_q.push_back(4'h3); exp_q.push_back(4'h4);
    read4(16'hBEEF, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
